// File: rtl/qsys_serial_responder_if.sv
// Qsys serial responder bus bundle: host serial link pins plus the local
// register port.
//   slave  modport : responder view (drives sdo/srdy, register strobes, error pulses)
//   master modport : environment view (drives sdi/sle, reg_readdata/reg_ack)
interface qsys_serial_responder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              sdi;
  logic              sle;
  logic              sdo;
  logic              srdy;
  logic [ADDR_W-1:0] reg_address;
  logic [31:0]       reg_writedata;
  logic              reg_write;
  logic              reg_read;
  logic [31:0]       reg_readdata;
  logic              reg_ack;
  logic              frame_err;
  logic              timeout_err;

  modport slave (
    input  sdi, sle, reg_readdata, reg_ack,
    output sdo, srdy, reg_address, reg_writedata, reg_write, reg_read,
           frame_err, timeout_err
  );

  modport master (
    output sdi, sle, reg_readdata, reg_ack,
    input  sdo, srdy, reg_address, reg_writedata, reg_write, reg_read,
           frame_err, timeout_err
  );
endinterface

// File: rtl/qsys_serial_responder.sv
// Device-end responder for the Qsys serial link.
// Deserialises request frames (R/W, 32-bit address, 32-bit data, MSB first)
// from sdi/sle, performs the access on the local register port, then answers
// with srdy (1 cycle for writes, 32 cycles for reads with sdo carrying the
// read data MSB first).
// Ports:
//   csi_MCLK_clk   : link/system clock
//   rsi_MRST_reset : synchronous active-high reset
//   bus (slave)    : sdi, sle, sdo, srdy, reg_address, reg_writedata,
//                    reg_write, reg_read, reg_readdata, reg_ack,
//                    frame_err, timeout_err
// Build option: define SERIAL_PARITY_EN for a 66-bit frame whose last bit is
// odd parity over the preceding 65 bits.
module qsys_serial_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input logic                    csi_MCLK_clk,
  input logic                    rsi_MRST_reset,
  qsys_serial_responder_if.slave bus
);

`ifdef SERIAL_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned FRAME_W = 65 + PB;
  localparam int unsigned SR_W    = FRAME_W - 1;
  localparam int unsigned CW      = 7;
  localparam int unsigned TW      = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {SYNC, IDLE, SHIFT, EXEC, RESP, DRAIN} state_t;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [CW-1:0]     cnt;
  logic [TW-1:0]     tcnt;
  logic [4:0]        bcnt;
  logic [31:0]       rdata;
  logic              is_wr;

  // Fields of the frame completing this cycle: sr holds all earlier bits,
  // sdi carries the final bit.
  logic              f_rw;
  logic [ADDR_W-1:0] f_addr;
  logic [31:0]       f_data;
  assign f_rw   = sr[63+PB];
  assign f_addr = sr[31+PB +: ADDR_W];
`ifdef SERIAL_PARITY_EN
  assign f_data = sr[31:0];
  logic parity_ok;
  assign parity_ok = ^{sr, bus.sdi};
`else
  assign f_data = {sr[30:0], bus.sdi};
`endif

  // Frame receive, local access, and serial response sequencing.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      state             <= SYNC;
      sr                <= '0;
      cnt               <= '0;
      tcnt              <= '0;
      bcnt              <= '0;
      rdata             <= '0;
      is_wr             <= 1'b0;
      bus.sdo           <= 1'b0;
      bus.srdy          <= 1'b0;
      bus.reg_address   <= '0;
      bus.reg_writedata <= '0;
      bus.reg_write     <= 1'b0;
      bus.reg_read      <= 1'b0;
      bus.frame_err     <= 1'b0;
      bus.timeout_err   <= 1'b0;
    end else begin
      bus.frame_err   <= 1'b0;
      bus.timeout_err <= 1'b0;
      case (state)
        // Never lock on mid-frame: require a quiet sle first.
        SYNC: if (!bus.sle) state <= IDLE;

        IDLE: begin
          if (bus.sle) begin
            sr    <= {sr[SR_W-2:0], bus.sdi};
            cnt   <= CW'(1);
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (!bus.sle) begin
            bus.frame_err <= 1'b1;
            state         <= IDLE;
          end else begin
            sr  <= {sr[SR_W-2:0], bus.sdi};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(FRAME_W - 1)) begin
              is_wr             <= f_rw;
              bus.reg_address   <= f_addr;
              bus.reg_writedata <= f_data;
              tcnt              <= '0;
`ifdef SERIAL_PARITY_EN
              if (!parity_ok) begin
                // Bad parity: skip the local access, answer as if timed out.
                bus.frame_err <= 1'b1;
                bus.srdy      <= 1'b1;
                bus.sdo       <= f_rw ? 1'b0 : ERR_DATA[31];
                rdata         <= {ERR_DATA[30:0], 1'b0};
                bcnt          <= '0;
                state         <= RESP;
              end else begin
                bus.reg_write <= f_rw;
                bus.reg_read  <= ~f_rw;
                state         <= EXEC;
              end
`else
              bus.reg_write <= f_rw;
              bus.reg_read  <= ~f_rw;
              state         <= EXEC;
`endif
            end
          end
        end

        EXEC: begin
          if (bus.reg_ack) begin
            bus.reg_write <= 1'b0;
            bus.reg_read  <= 1'b0;
            bus.srdy      <= 1'b1;
            bus.sdo       <= is_wr ? 1'b0 : bus.reg_readdata[31];
            rdata         <= {bus.reg_readdata[30:0], 1'b0};
            bcnt          <= '0;
            state         <= RESP;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            bus.reg_write   <= 1'b0;
            bus.reg_read    <= 1'b0;
            bus.timeout_err <= 1'b1;
            bus.srdy        <= 1'b1;
            bus.sdo         <= is_wr ? 1'b0 : ERR_DATA[31];
            rdata           <= {ERR_DATA[30:0], 1'b0};
            bcnt            <= '0;
            state           <= RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        // rdata holds the not-yet-sent bits left-aligned.
        RESP: begin
          if (is_wr || bcnt == 5'd31) begin
            bus.srdy <= 1'b0;
            bus.sdo  <= 1'b0;
            state    <= DRAIN;
          end else begin
            bcnt    <= bcnt + 5'd1;
            bus.sdo <= rdata[31];
            rdata   <= {rdata[30:0], 1'b0};
          end
        end

        DRAIN: if (!bus.sle) state <= IDLE;

        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_qsys_serial_responder.sv
// Scoreboard bench for qsys_serial_responder: stimulus pushes expected local
// accesses and expected serial responses; independent monitors pop and check.
module tb_qsys_serial_responder;

`ifdef SERIAL_PARITY_EN
  localparam int FW = 66;
`else
  localparam int FW = 65;
`endif

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          len;
  } acc_t;

  typedef struct {
    int          len;
    logic [31:0] data;
  } resp_t;

  logic clk;
  logic rst;
  qsys_serial_responder_if #(.ADDR_W(8)) bus ();

  qsys_serial_responder #(.ADDR_W(8), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .csi_MCLK_clk   (clk),
    .rsi_MRST_reset (rst),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  acc_t  acc_q[$];
  resp_t resp_q[$];

  // Local slave model knobs
  int          ack_delay = 1;      // strobe cycles before ack; <=0 means never
  logic [31:0] ack_data  = '0;
  bit          spurious  = 1'b0;   // drive reg_ack while no strobe

  int fe_cnt = 0;
  int to_cnt = 0;
  int sdo_glitch = 0;
  bit in_acc = 1'b0;
  bit in_resp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Local register slave
  initial begin
    int scnt;
    scnt = 0;
    bus.reg_ack      = 1'b0;
    bus.reg_readdata = '0;
    forever begin
      @(negedge clk);
      if (bus.reg_write || bus.reg_read) begin
        scnt++;
        bus.reg_ack      = (ack_delay > 0 && scnt == ack_delay);
        bus.reg_readdata = ack_data;
      end else begin
        scnt             = 0;
        bus.reg_ack      = spurious;
        bus.reg_readdata = 32'h0BAD0BAD;
      end
    end
  end

  // Local access monitor
  initial begin
    acc_t cur;
    bit   have;
    int   alen;
    logic stb;
    have = 1'b0;
    alen = 0;
    forever begin
      @(negedge clk);
      stb = bus.reg_write | bus.reg_read;
      if (stb && !in_acc) begin
        in_acc = 1'b1;
        alen   = 0;
        if (acc_q.size() == 0) begin
          tests++; fails++; have = 1'b0;
          $display("FAIL acc_unexpected actual addr=%h required none", bus.reg_address);
        end else begin
          cur  = acc_q.pop_front();
          have = 1'b1;
          check("acc_kind", 64'({bus.reg_write, bus.reg_read}), cur.wr ? 64'd2 : 64'd1);
          check("acc_addr", 64'(bus.reg_address), 64'(cur.addr));
          if (cur.wr) check("acc_wdata", 64'(bus.reg_writedata), 64'(cur.wdata));
        end
      end
      if (stb) alen++;
      if (!stb && in_acc) begin
        in_acc = 1'b0;
        if (have) check("acc_len", 64'(alen), 64'(cur.len));
      end
      if (bus.frame_err) fe_cnt++;
      if (bus.timeout_err) to_cnt++;
    end
  end

  // Serial response monitor
  initial begin
    int          rlen;
    logic [31:0] rword;
    resp_t       e;
    rlen  = 0;
    rword = '0;
    forever begin
      @(negedge clk);
      if (bus.srdy) begin
        if (!in_resp) begin
          in_resp = 1'b1;
          rlen    = 0;
          rword   = '0;
        end
        rlen++;
        rword = {rword[30:0], bus.sdo};
      end else begin
        if (bus.sdo) sdo_glitch++;
        if (in_resp) begin
          in_resp = 1'b0;
          if (resp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL resp_unexpected actual len=%0d data=%h required none", rlen, rword);
          end else begin
            e = resp_q.pop_front();
            check("resp_len", 64'(rlen), 64'(e.len));
            check("resp_data", 64'(rword), 64'(e.data));
          end
        end
      end
    end
  end

  function automatic logic [FW-1:0] mk_frame(input bit rw, input logic [31:0] a,
                                             input logic [31:0] d, input bit flip);
    logic [64:0] p;
    p = {rw, a, d};
`ifdef SERIAL_PARITY_EN
    return {p, (~^p) ^ flip};
`else
    return p ^ 65'(flip);
`endif
  endfunction

  task automatic send_frame(input bit rw, input logic [31:0] a, input logic [31:0] d,
                            input int nbits, input bit flip);
    logic [FW-1:0] fv;
    fv = mk_frame(rw, a, d, flip);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.sle = 1'b1;
      bus.sdi = (i < FW) ? fv[FW-1-i] : 1'b1;
    end
    @(negedge clk);
    bus.sle = 1'b0;
    bus.sdi = 1'b0;
  endtask

  task automatic push_acc(input bit wr, input logic [7:0] a, input logic [31:0] d, input int len);
    acc_t x;
    x.wr = wr; x.addr = a; x.wdata = d; x.len = len;
    acc_q.push_back(x);
  endtask

  task automatic push_resp(input int len, input logic [31:0] d);
    resp_t x;
    x.len = len; x.data = d;
    resp_q.push_back(x);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((acc_q.size() != 0 || resp_q.size() != 0 || in_acc || in_resp) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      tests++; fails++;
      $display("FAIL %s_timeout actual acc_q=%0d resp_q=%0d required 0/0", name,
               acc_q.size(), resp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    bus.sle = 1'b0;
    bus.sdi = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({bus.srdy, bus.sdo, bus.reg_write, bus.reg_read, bus.frame_err,
               bus.timeout_err, bus.reg_address, bus.reg_writedata}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: write, ack after 3 strobe cycles; upper address bits ignored
    ack_delay = 3;
    push_acc(1'b1, 8'h05, 32'h12345678, 3);
    push_resp(1, 32'h0);
    send_frame(1'b1, 32'hABCD0005, 32'h12345678, FW, 1'b0);
    wait_done("t1");

    // 2: read with immediate ack
    ack_delay = 1;
    ack_data  = 32'hA5A50F0F;
    push_acc(1'b0, 8'h10, 32'h0, 1);
    push_resp(32, 32'hA5A50F0F);
    send_frame(1'b0, 32'h00000010, 32'h0, FW, 1'b0);
    wait_done("t2");

    // 3: short frame, then a normal write
    send_frame(1'b1, 32'h00000044, 32'hFFFFFFFF, 40, 1'b0);
    repeat (5) @(negedge clk);
    check("t3_frame_err", 64'(fe_cnt), 64'd1);
    ack_delay = 2;
    push_acc(1'b1, 8'h22, 32'hCAFEF00D, 2);
    push_resp(1, 32'h0);
    send_frame(1'b1, 32'h00000022, 32'hCAFEF00D, FW, 1'b0);
    wait_done("t3");

    // 4: read with no ack -> timeout
    ack_delay = 0;
    push_acc(1'b0, 8'h33, 32'h0, 16);
    push_resp(32, 32'hDEADBEEF);
    send_frame(1'b0, 32'h00000033, 32'h0, FW, 1'b0);
    wait_done("t4");
    check("t4_timeout_err", 64'(to_cnt), 64'd1);

    // ack with no strobe must be ignored
    spurious = 1'b1;
    repeat (10) @(negedge clk);
    spurious = 1'b0;
    repeat (3) @(negedge clk);

    // 5: reset after 30 bits with sle held high, then a long write frame
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus.sle = 1'b1;
      bus.sdi = i[0];
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_reset_outputs",
          64'({bus.srdy, bus.sdo, bus.reg_write, bus.reg_read, bus.frame_err,
               bus.timeout_err, bus.reg_address, bus.reg_writedata}), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    bus.sle = 1'b0;
    repeat (5) @(negedge clk);
    ack_delay = 1;
    push_acc(1'b1, 8'h7F, 32'h0000FFFF, 1);
    push_resp(1, 32'h0);
    send_frame(1'b1, 32'h0000007F, 32'h0000FFFF, FW + 5, 1'b0);
    wait_done("t5");
    check("t5_frame_err", 64'(fe_cnt), 64'd1);

`ifdef SERIAL_PARITY_EN
    // 6: parity errors (write and read), then a correct write
    push_resp(1, 32'h0);
    send_frame(1'b1, 32'h00000011, 32'h11112222, FW, 1'b1);
    wait_done("t6a");
    check("t6_frame_err_w", 64'(fe_cnt), 64'd2);
    push_resp(32, 32'hDEADBEEF);
    send_frame(1'b0, 32'h00000012, 32'h0, FW, 1'b1);
    wait_done("t6b");
    check("t6_frame_err_r", 64'(fe_cnt), 64'd3);
    push_acc(1'b1, 8'h13, 32'h33334444, 1);
    push_resp(1, 32'h0);
    send_frame(1'b1, 32'h00000013, 32'h33334444, FW, 1'b0);
    wait_done("t6c");
    check("t6_frame_err_ok", 64'(fe_cnt), 64'd3);
`endif

    check("timeout_err_total", 64'(to_cnt), 64'd1);
    check("sdo_idle_zero", 64'(sdo_glitch), 64'd0);
    check("acc_q_empty", 64'(acc_q.size()), 64'd0);
    check("resp_q_empty", 64'(resp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
